multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/ctrl_defs.sv | 77 +++++++
 rtl/alu_decode.sv | 38 +++
 rtl/multicycle_control.sv | 163 ++++++++++++++++
 tb/tb_multicycle_control.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_defs.sv
// Shared definitions for the multicycle controller: state encoding, decode constants.
// Latency: n/a (package only).
// Backpressure: n/a.
//
// Holds the FSM state type, the opcode/funct values the decoder recognises,
// ALU command codes and the mux select codes driven onto the datapath.
package ctrl_defs;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_WB_R     = 4'd7,
        S_EXEC_I   = 4'd8,
        S_WB_I     = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11,
        S_JAL      = 4'd12,
        S_JR       = 4'd13,
        S_HALT     = 4'd14
    } state_t;

    // Opcodes (IR[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (IR[5:0])
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_SLT = 6'h2A;

    // ALU command codes (sized to the ALU_W parameter at the point of use)
    localparam int ALU_ADD = 0;
    localparam int ALU_SUB = 1;
    localparam int ALU_XOR = 2;
    localparam int ALU_SLT = 3;

    // Memory address select
    localparam logic IORD_PC  = 1'b0;
    localparam logic IORD_ALU = 1'b1;

    // Register destination select
    localparam logic [1:0] DST_RT  = 2'd0;
    localparam logic [1:0] DST_RD  = 2'd1;
    localparam logic [1:0] DST_R31 = 2'd2;

    // Writeback source select
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MDR = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    // ALU operand selects
    localparam logic       SRCA_PC  = 1'b0;
    localparam logic       SRCA_RS  = 1'b1;
    localparam logic [1:0] SRCB_RT  = 2'd0;
    localparam logic [1:0] SRCB_4   = 2'd1;
    localparam logic [1:0] SRCB_IMM = 2'd2;
    localparam logic [1:0] SRCB_BR  = 2'd3;

    // PC next select
    localparam logic [1:0] PC_ALU    = 2'd0;
    localparam logic [1:0] PC_ALUOUT = 2'd1;
    localparam logic [1:0] PC_JTGT   = 2'd2;
    localparam logic [1:0] PC_RS     = 2'd3;

endpackage

// File: rtl/alu_decode.sv
// ALU command decode from controller state plus instruction fields.
// Latency: combinational, zero cycles.
// Backpressure: none.
//
// Ports: state_i (current FSM state), opcode_i / funct_i (IR fields),
//        alu_cmd_o (ALU command, ADD whenever the state does not name one).
module alu_decode
    import ctrl_defs::*;
#(
    parameter int ALU_W = 3
) (
    input  state_t           state_i,
    input  logic [5:0]       opcode_i,
    input  logic [5:0]       funct_i,
    output logic [ALU_W-1:0] alu_cmd_o
);

    always_comb begin
        alu_cmd_o = ALU_W'(ALU_ADD);
        case (state_i)
            S_EXEC_R: begin
                case (funct_i)
                    FN_SUB:  alu_cmd_o = ALU_W'(ALU_SUB);
                    FN_SLT:  alu_cmd_o = ALU_W'(ALU_SLT);
                    default: alu_cmd_o = ALU_W'(ALU_ADD);
                endcase
            end
            S_EXEC_I: begin
                if (opcode_i == OP_XORI) begin
                    alu_cmd_o = ALU_W'(ALU_XOR);
                end
            end
            S_BRANCH: alu_cmd_o = ALU_W'(ALU_SUB);
            default:  alu_cmd_o = ALU_W'(ALU_ADD);
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS-like datapath.
// Latency: LW 5 cycles; SW/R-type/ADDI/XORI 4; BNE/J/JAL/JR 3; illegal ops park in HALT.
// Backpressure: none; the datapath is assumed to complete every step in one cycle.
//
// Ports: clk, reset (sync, active-high); opcode/funct (IR fields, held stable
//        from DECODE until the next FETCH); zero (ALU flag, used only in BRANCH);
//        datapath enables/selects; alu_cmd; halt (sticky illegal-instruction flag).
module multicycle_control
    import ctrl_defs::*;
#(
    parameter int ALU_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic [5:0]       funct,
    input  logic             zero,
    output logic             pc_write,
    output logic             ir_write,
    output logic             iord,
    output logic             mem_we,
    output logic             reg_we,
    output logic [1:0]       reg_dst,
    output logic [1:0]       mem_to_reg,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [ALU_W-1:0] alu_cmd,
    output logic [1:0]       pc_src,
    output logic             halt
);

    state_t state_q, state_d;

    // Raw state decode before reset masking of the enables.
    logic pc_write_raw, ir_write_raw, mem_we_raw, reg_we_raw, halt_raw;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                    OP_RTYPE: begin
                        case (funct)
                            FN_JR:                  state_d = S_JR;
                            FN_ADD, FN_SUB, FN_SLT: state_d = S_EXEC_R;
                            default:                state_d = S_HALT;
                        endcase
                    end
                    OP_ADDI, OP_XORI: state_d = S_EXEC_I;
                    OP_BNE:           state_d = S_BRANCH;
                    OP_J:             state_d = S_JUMP;
                    OP_JAL:           state_d = S_JAL;
                    default:          state_d = S_HALT;
                endcase
            end
            S_MEM_ADDR: state_d = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   state_d = S_MEM_WB;
            S_EXEC_R:   state_d = S_WB_R;
            S_EXEC_I:   state_d = S_WB_I;
            S_MEM_WB, S_MEM_WR, S_WB_R, S_WB_I,
            S_BRANCH, S_JUMP, S_JAL, S_JR: state_d = S_FETCH;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Output decode: every output is a function of state_q alone, with the
    // single exception of pc_write in BRANCH, which follows !zero.
    always_comb begin
        pc_write_raw = 1'b0;
        ir_write_raw = 1'b0;
        mem_we_raw   = 1'b0;
        reg_we_raw   = 1'b0;
        halt_raw     = 1'b0;
        iord         = IORD_PC;
        reg_dst      = DST_RT;
        mem_to_reg   = WB_ALU;
        alu_src_a    = SRCA_PC;
        alu_src_b    = SRCB_RT;
        pc_src       = PC_ALU;
        case (state_q)
            S_FETCH: begin
                ir_write_raw = 1'b1;
                pc_write_raw = 1'b1;
                alu_src_b    = SRCB_4;
            end
            S_DECODE:   alu_src_b = SRCB_BR;
            S_MEM_ADDR: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_IMM;
            end
            S_MEM_RD:   iord = IORD_ALU;
            S_MEM_WB: begin
                reg_we_raw = 1'b1;
                mem_to_reg = WB_MDR;
            end
            S_MEM_WR: begin
                mem_we_raw = 1'b1;
                iord       = IORD_ALU;
            end
            S_EXEC_R:   alu_src_a = SRCA_RS;
            S_WB_R: begin
                reg_we_raw = 1'b1;
                reg_dst    = DST_RD;
            end
            S_EXEC_I: begin
                alu_src_a = SRCA_RS;
                alu_src_b = SRCB_IMM;
            end
            S_WB_I:     reg_we_raw = 1'b1;
            S_BRANCH: begin
                alu_src_a    = SRCA_RS;
                pc_src       = PC_ALUOUT;
                pc_write_raw = ~zero;
            end
            S_JUMP: begin
                pc_write_raw = 1'b1;
                pc_src       = PC_JTGT;
            end
            S_JAL: begin
                reg_we_raw   = 1'b1;
                reg_dst      = DST_R31;
                mem_to_reg   = WB_PC;
                pc_write_raw = 1'b1;
                pc_src       = PC_JTGT;
            end
            S_JR: begin
                pc_write_raw = 1'b1;
                pc_src       = PC_RS;
            end
            S_HALT:     halt_raw = 1'b1;
            default:    halt_raw = 1'b0;
        endcase
    end

    // Reset masks the enables combinationally so nothing is written while it
    // is held, even before the first edge has loaded a known state.
    assign pc_write = pc_write_raw & ~reset;
    assign ir_write = ir_write_raw & ~reset;
    assign mem_we   = mem_we_raw   & ~reset;
    assign reg_we   = reg_we_raw   & ~reset;
    assign halt     = halt_raw     & ~reset;

    alu_decode #(
        .ALU_W (ALU_W)
    ) u_alu_decode (
        .state_i   (state_q),
        .opcode_i  (opcode),
        .funct_i   (funct),
        .alu_cmd_o (alu_cmd)
    );

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed scenarios plus random instruction stream.
// Latency: n/a.
// Backpressure: n/a.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       pc_write, ir_write, iord, mem_we, reg_we, alu_src_a, halt;
    logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
    logic [2:0] alu_cmd;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic       pc_write;
        logic       ir_write;
        logic       iord;
        logic       mem_we;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_cmd;
        logic [1:0] pc_src;
        logic       halt;
    } ov_t;

    ov_t obs;
    assign obs = {pc_write, ir_write, iord, mem_we, reg_we, reg_dst, mem_to_reg,
                  alu_src_a, alu_src_b, alu_cmd, pc_src, halt};

    always #5 clk = ~clk;

    multicycle_control #(.ALU_W(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .funct      (funct),
        .zero       (zero),
        .pc_write   (pc_write),
        .ir_write   (ir_write),
        .iord       (iord),
        .mem_we     (mem_we),
        .reg_we     (reg_we),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_cmd    (alu_cmd),
        .pc_src     (pc_src),
        .halt       (halt)
    );

    // Instruction classes of the reference model.
    localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BNE = 4,
                   K_J = 5, K_JAL = 6, K_JR = 7, K_ILL = 8;

    function automatic int classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h23: return K_LW;
            6'h2B: return K_SW;
            6'h00: begin
                if (fn == 6'h08) return K_JR;
                if (fn == 6'h20 || fn == 6'h22 || fn == 6'h2A) return K_R;
                return K_ILL;
            end
            6'h08, 6'h0E: return K_I;
            6'h05: return K_BNE;
            6'h02: return K_J;
            6'h03: return K_JAL;
            default: return K_ILL;
        endcase
    endfunction

    function automatic int latency(input int kind);
        case (kind)
            K_LW:                  return 5;
            K_SW, K_R, K_I:        return 4;
            K_BNE, K_J, K_JAL, K_JR: return 3;
            default:               return 2; // FETCH + DECODE, then parked
        endcase
    endfunction

    // Expected outputs for step k of an instruction of the given class.
    function automatic ov_t exp_step(input int kind, input int k, input logic z,
                                     input logic [5:0] op, input logic [5:0] fn);
        ov_t e;
        e = '0;
        if (k == 0) begin
            e.pc_write = 1'b1; e.ir_write = 1'b1; e.alu_src_b = 2'd1;
        end else if (k == 1) begin
            e.alu_src_b = 2'd3;
        end else begin
            case (kind)
                K_LW, K_SW: begin
                    if (k == 2) begin
                        e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                    end else if (kind == K_SW) begin
                        e.mem_we = 1'b1; e.iord = 1'b1;
                    end else if (k == 3) begin
                        e.iord = 1'b1;
                    end else begin
                        e.reg_we = 1'b1; e.mem_to_reg = 2'd1;
                    end
                end
                K_R: begin
                    if (k == 2) begin
                        e.alu_src_a = 1'b1;
                        e.alu_cmd = (fn == 6'h22) ? 3'd1 : (fn == 6'h2A) ? 3'd3 : 3'd0;
                    end else begin
                        e.reg_we = 1'b1; e.reg_dst = 2'd1;
                    end
                end
                K_I: begin
                    if (k == 2) begin
                        e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
                        e.alu_cmd = (op == 6'h0E) ? 3'd2 : 3'd0;
                    end else begin
                        e.reg_we = 1'b1;
                    end
                end
                K_BNE: begin
                    e.alu_src_a = 1'b1; e.alu_cmd = 3'd1; e.pc_src = 2'd1;
                    e.pc_write = ~z;
                end
                K_J:   begin e.pc_write = 1'b1; e.pc_src = 2'd2; end
                K_JAL: begin
                    e.pc_write = 1'b1; e.pc_src = 2'd2;
                    e.reg_we = 1'b1; e.reg_dst = 2'd2; e.mem_to_reg = 2'd2;
                end
                K_JR:  begin e.pc_write = 1'b1; e.pc_src = 2'd3; end
                default: e.halt = 1'b1;
            endcase
        end
        return e;
    endfunction

    // Pulse reset for one edge from wherever the FSM is; leaves the DUT in its first FETCH.
    task automatic do_reset(input string name);
        reset = 1'b1;
        #1;
        total++;
        if ({pc_write, ir_write, mem_we, reg_we, halt} !== 5'b0) begin
            bad++;
            $display("FAIL %s reset_hold_pre got=%b exp=00000", name,
                     {pc_write, ir_write, mem_we, reg_we, halt});
        end
        @(posedge clk); #1;
        total++;
        if ({pc_write, ir_write, mem_we, reg_we, halt} !== 5'b0) begin
            bad++;
            $display("FAIL %s reset_hold_post got=%b exp=00000", name,
                     {pc_write, ir_write, mem_we, reg_we, halt});
        end
        reset = 1'b0;
        #1;
        total++;
        if (obs !== exp_step(K_LW, 0, 1'b0, 6'h0, 6'h0)) begin
            bad++;
            $display("FAIL %s first_fetch got=%h exp=%h", name, obs,
                     exp_step(K_LW, 0, 1'b0, 6'h0, 6'h0));
        end
    endtask

    // Run one instruction starting in FETCH; checks every cycle of it.
    // Illegal instructions are watched for `hold` HALT cycles and then reset.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int hold, input string name);
        int  kind;
        int  lat;
        ov_t e;
        kind = classify(op, fn);
        lat  = latency(kind) + ((kind == K_ILL) ? hold : 0);
        opcode = op; funct = fn; zero = z;
        #1;
        for (int k = 0; k < lat; k++) begin
            e = exp_step(kind, k, z, op, fn);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL %s op=%h fn=%h cyc=%0d got=%h exp=%h", name, op, fn, k, obs, e);
            end
            total++;
            if ((mem_we & ir_write) !== 1'b0) begin
                bad++;
                $display("FAIL %s we_ir_excl cyc=%0d got=1 exp=0", name, k);
            end
            @(posedge clk); #1;
        end
        if (kind == K_ILL) do_reset(name);
    endtask

    task automatic test_reset();
        opcode = 6'h00; funct = 6'h20; zero = 1'b0;
        do_reset("reset");
    endtask

    task automatic test_lw();
        run_instr(6'h23, 6'h11, 1'b0, 0, "lw");
    endtask

    task automatic test_sw();
        run_instr(6'h2B, 6'h3F, 1'b1, 0, "sw");
    endtask

    task automatic test_bne();
        run_instr(6'h05, 6'h00, 1'b1, 0, "bne_taken_no");
        run_instr(6'h05, 6'h00, 1'b0, 0, "bne_taken_yes");
    endtask

    task automatic test_rtype();
        run_instr(6'h00, 6'h2A, 1'b0, 0, "slt");
        run_instr(6'h00, 6'h22, 1'b0, 0, "sub");
        run_instr(6'h0E, 6'h05, 1'b0, 0, "xori");
    endtask

    task automatic test_jumps();
        run_instr(6'h03, 6'h00, 1'b0, 0, "jal");
        run_instr(6'h00, 6'h08, 1'b1, 0, "jr");
        run_instr(6'h02, 6'h15, 1'b0, 0, "j");
    endtask

    task automatic test_halt();
        run_instr(6'h3F, 6'h00, 1'b0, 12, "halt");
        run_instr(6'h00, 6'h21, 1'b0, 2, "halt_bad_funct");
    endtask

    task automatic test_reset_mid();
        ov_t e;
        opcode = 6'h23; funct = 6'h00; zero = 1'b0;
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_step(K_LW, k, 1'b0, 6'h23, 6'h00);
            total++;
            if (obs !== e) begin
                bad++;
                $display("FAIL reset_mid lead cyc=%0d got=%h exp=%h", k, obs, e);
            end
            if (k < 3) begin
                @(posedge clk); #1;
            end
        end
        // Now in MEM_RD: reset must abandon the load and return to FETCH.
        do_reset("reset_mid");
        run_instr(6'h2B, 6'h00, 1'b0, 0, "after_reset_mid");
    endtask

    task automatic test_random();
        logic [5:0] ops [11];
        logic [5:0] fns [11];
        logic [5:0] op, fn;
        int idx;
        ops = '{6'h23, 6'h2B, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h0E, 6'h05, 6'h02, 6'h03};
        fns = '{6'h00, 6'h00, 6'h20, 6'h22, 6'h2A, 6'h08, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                op = 6'($urandom_range(0, 63));
                fn = 6'($urandom_range(0, 63));
            end else begin
                idx = $urandom_range(0, 10);
                op  = ops[idx];
                fn  = (op == 6'h00) ? fns[idx] : 6'($urandom_range(0, 63));
            end
            run_instr(op, fn, 1'($urandom_range(0, 1)), 3, "random");
        end
    endtask

    initial begin
        reset = 1'b1;
        opcode = '0; funct = '0; zero = 1'b0;
        test_reset();
        test_lw();
        test_sw();
        test_bne();
        test_rtype();
        test_jumps();
        test_halt();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
